// File: rtl/hazard_forward_ctrl.sv
// Load-use hazard detection and operand-forwarding control for a 5-stage pipeline.
// Shadows the EX/MEM/WB control fields and produces the stall and EX operand-mux selects.
module hazard_forward_ctrl #(
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_use_src1,
    input  logic                  id_use_src2,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  id_wb_en,
    input  logic                  id_mem_read,
    input  logic                  branch_taken,
    output logic                  stall,
    output logic [1:0]            fwd_sel_a,
    output logic [1:0]            fwd_sel_b,
    output logic                  ex_valid,
    output logic [CNT_W-1:0]      stall_count
);

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] dest;
        logic                  wb_en;
        logic                  mem_read;
    } stage_t;

    stage_t ex_reg, mem_reg, wb_reg, ex_next;
    logic [1:0]       fwd_a_reg, fwd_b_reg, fwd_a_next, fwd_b_next;
    logic [CNT_W-1:0] cnt_reg;

    logic [1:0][REG_ADDR_W-1:0] src;
    logic [1:0]                 use_src;
    logic [1:0]                 ld_hit;
    logic [1:0][1:0]            sel_next;
    logic                       load_use;
    logic                       issue;

    assign src     = {id_src2, id_src1};
    assign use_src = {id_use_src2, id_use_src1};

    // EX is checked before MEM so the youngest producer of a register wins.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_operand
            logic ex_hit, mem_hit;
            assign ex_hit  = use_src[gi] & (src[gi] != '0) & ex_reg.valid
                           & ex_reg.wb_en & (ex_reg.dest == src[gi]);
            assign mem_hit = use_src[gi] & (src[gi] != '0) & mem_reg.valid
                           & mem_reg.wb_en & (mem_reg.dest == src[gi]);
            assign ld_hit[gi]   = use_src[gi] & (src[gi] == ex_reg.dest);
            assign sel_next[gi] = ex_hit ? 2'd1 : (mem_hit ? 2'd2 : 2'd0);
        end
    endgenerate

    assign load_use = id_valid & ex_reg.valid & ex_reg.mem_read & ex_reg.wb_en
                    & (ex_reg.dest != '0) & (|ld_hit);
    assign stall    = load_use & ~branch_taken;
    assign issue    = id_valid & ~stall & ~branch_taken;

    always_comb begin
        ex_next    = '0;
        fwd_a_next = 2'd0;
        fwd_b_next = 2'd0;
        if (issue) begin
            ex_next.valid    = 1'b1;
            ex_next.dest     = id_dest;
            ex_next.wb_en    = id_wb_en;
            ex_next.mem_read = id_mem_read;
            fwd_a_next       = sel_next[0];
            fwd_b_next       = sel_next[1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_reg    <= '0;
            mem_reg   <= '0;
            wb_reg    <= '0;
            fwd_a_reg <= 2'd0;
            fwd_b_reg <= 2'd0;
            cnt_reg   <= '0;
        end else begin
            ex_reg    <= ex_next;
            mem_reg   <= ex_reg;
            wb_reg    <= mem_reg;
            fwd_a_reg <= fwd_a_next;
            fwd_b_reg <= fwd_b_next;
            if (stall && (cnt_reg != '1))
                cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    // WB and MEM.mem_read are tracked for completeness; the register file is
    // write-before-read, so nothing forwards from WB.
    logic unused_wb;
    assign unused_wb = &{1'b0, wb_reg, mem_reg.mem_read};

    assign fwd_sel_a   = fwd_a_reg;
    assign fwd_sel_b   = fwd_b_reg;
    assign ex_valid    = ex_reg.valid;
    assign stall_count = cnt_reg;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Bench for hazard_forward_ctrl: directed pipeline scenarios plus random traffic,
// checked every cycle against an instruction-history model.
module tb_hazard_forward_ctrl;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         id_valid = 1'b0, id_use_src1 = 1'b0, id_use_src2 = 1'b0;
    logic [W-1:0] id_src1 = '0, id_src2 = '0, id_dest = '0;
    logic         id_wb_en = 1'b0, id_mem_read = 1'b0, branch_taken = 1'b0;
    logic         stall, ex_valid, stall_s, ex_valid_s;
    logic [1:0]   fwd_sel_a, fwd_sel_b, fwd_sel_a_s, fwd_sel_b_s;
    logic [15:0]  stall_count;
    logic [3:0]   stall_count_s;

    always #5 clk = ~clk;

    hazard_forward_ctrl #(.REG_ADDR_W(W), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_use_src1(id_use_src1), .id_use_src2(id_use_src2), .id_dest(id_dest),
        .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .branch_taken(branch_taken),
        .stall(stall), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
        .ex_valid(ex_valid), .stall_count(stall_count)
    );

    // Narrow-counter copy on the same stimulus, so saturation is reachable quickly.
    hazard_forward_ctrl #(.REG_ADDR_W(W), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_use_src1(id_use_src1), .id_use_src2(id_use_src2), .id_dest(id_dest),
        .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .branch_taken(branch_taken),
        .stall(stall_s), .fwd_sel_a(fwd_sel_a_s), .fwd_sel_b(fwd_sel_b_s),
        .ex_valid(ex_valid_s), .stall_count(stall_count_s)
    );

    typedef struct {
        bit v;
        int dest;
        bit wb;
        bit ld;
    } ins_t;

    // hist[0] is the instruction now in EX, hist[1] the one in MEM.
    ins_t hist[2];
    int   m_fa, m_fb, m_cnt;
    int   vectors = 0, miscompares = 0;
    bit   last_stall;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 2; i++) begin
            hist[i].v = 0; hist[i].dest = 0; hist[i].wb = 0; hist[i].ld = 0;
        end
        m_fa = 0; m_fb = 0; m_cnt = 0;
    endfunction

    // Distance (1 = EX, 2 = MEM) to the youngest in-flight writer of src, 0 if none.
    function automatic int producer(input bit use_it, input int s);
        if (!use_it || s == 0) return 0;
        for (int a = 0; a < 2; a++)
            if (hist[a].v && hist[a].wb && hist[a].dest == s) return a + 1;
        return 0;
    endfunction

    task automatic drive_idle();
        id_valid = 0; id_use_src1 = 0; id_use_src2 = 0; id_src1 = '0; id_src2 = '0;
        id_dest = '0; id_wb_en = 0; id_mem_read = 0; branch_taken = 0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        model_clear();
    endtask

    // One ID-stage transaction: drive at negedge, check, advance model on posedge.
    task automatic step(input bit v, input int s1, input bit u1, input int s2, input bit u2,
                        input int d, input bit wb, input bit ld, input bit br);
        bit   es, issue;
        int   na, nb;
        ins_t ni;
        id_valid = v; id_src1 = W'(s1); id_use_src1 = u1; id_src2 = W'(s2);
        id_use_src2 = u2; id_dest = W'(d); id_wb_en = wb; id_mem_read = ld; branch_taken = br;
        #1;
        es = v && !br && hist[0].v && hist[0].ld && hist[0].wb && hist[0].dest != 0 &&
             ((u1 && s1 == hist[0].dest) || (u2 && s2 == hist[0].dest));
        last_stall = stall;
        chk("stall", int'(stall), int'(es));
        chk("fwd_sel_a", int'(fwd_sel_a), m_fa);
        chk("fwd_sel_b", int'(fwd_sel_b), m_fb);
        chk("ex_valid", int'(ex_valid), int'(hist[0].v));
        chk("stall_count", int'(stall_count), m_cnt);
        chk("stall_count_sat4", int'(stall_count_s), (m_cnt > 15) ? 15 : m_cnt);
        $display("txn t=%0t v=%0d s1=%0d/%0d s2=%0d/%0d d=%0d wb=%0d ld=%0d br=%0d | stall=%0d fa=%0d fb=%0d exv=%0d cnt=%0d",
                 $time, v, s1, u1, s2, u2, d, wb, ld, br, stall, fwd_sel_a, fwd_sel_b,
                 ex_valid, stall_count);
        issue = v && !es && !br;
        na = issue ? producer(u1, s1) : 0;
        nb = issue ? producer(u2, s2) : 0;
        ni.v = issue; ni.dest = issue ? d : 0; ni.wb = issue && wb; ni.ld = issue && ld;
        @(posedge clk);
        hist[1] = hist[0];
        hist[0] = ni;
        m_fa = na; m_fb = nb;
        if (es && m_cnt < 65535) m_cnt++;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        do_reset();
        chk("reset_ex_valid", int'(ex_valid), 0);
        chk("reset_stall", int'(stall), 0);
        chk("reset_count", int'(stall_count), 0);

        // add r3 then sub using r3: forwarded from EX/MEM, no stall
        step(1, 1, 1, 2, 1, 3, 1, 0, 0);
        step(1, 3, 1, 2, 1, 6, 1, 0, 0);
        chk("d_sub_fwd_a", int'(fwd_sel_a), 1);
        chk("d_sub_fwd_b", int'(fwd_sel_b), 0);
        chk("d_sub_nostall", int'(last_stall), 0);

        // add r3, unrelated, then use r3 as src2: forwarded from MEM/WB
        do_reset();
        step(1, 1, 1, 2, 1, 3, 1, 0, 0);
        step(1, 7, 1, 8, 1, 9, 1, 0, 0);
        step(1, 1, 1, 3, 1, 10, 1, 0, 0);
        chk("d_mem_fwd_b", int'(fwd_sel_b), 2);

        // load r5 then use r5: one stall, one bubble, then forward from MEM/WB
        do_reset();
        step(1, 1, 0, 0, 0, 5, 1, 1, 0);
        step(1, 5, 1, 0, 0, 6, 1, 0, 0);
        chk("d_lu_stall", int'(last_stall), 1);
        chk("d_lu_bubble", int'(ex_valid), 0);
        step(1, 5, 1, 0, 0, 6, 1, 0, 0);
        chk("d_lu_stall_once", int'(last_stall), 0);
        chk("d_lu_fwd_a", int'(fwd_sel_a), 2);
        chk("d_lu_count", int'(stall_count), 1);

        // two writers of r4: youngest wins; r0 is never forwarded
        do_reset();
        step(1, 1, 1, 2, 1, 4, 1, 0, 0);
        step(1, 1, 1, 2, 1, 4, 1, 0, 0);
        step(1, 4, 1, 0, 0, 7, 1, 0, 0);
        chk("d_youngest", int'(fwd_sel_a), 1);
        step(1, 1, 1, 2, 1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 1, 8, 1, 0, 0);
        chk("d_r0_a", int'(fwd_sel_a), 0);
        chk("d_r0_b", int'(fwd_sel_b), 0);

        // load-use coincident with branch: flush wins
        do_reset();
        step(1, 1, 0, 0, 0, 5, 1, 1, 0);
        step(1, 5, 1, 0, 0, 6, 1, 0, 1);
        chk("d_br_nostall", int'(last_stall), 0);
        chk("d_br_bubble", int'(ex_valid), 0);
        chk("d_br_count", int'(stall_count), 0);

        // asynchronous reset in the middle of a stall
        do_reset();
        step(1, 1, 1, 2, 1, 3, 1, 0, 0);
        step(1, 3, 1, 0, 0, 5, 1, 1, 0);
        chk("d_ar_pre_fwd", int'(fwd_sel_a), 1);
        id_valid = 1; id_src1 = W'(5); id_use_src1 = 1; id_dest = W'(6); id_wb_en = 1;
        id_mem_read = 0;
        #1;
        chk("d_ar_stall_pre", int'(stall), 1);
        rst = 1;
        #1;
        chk("d_ar_stall", int'(stall), 0);
        chk("d_ar_ex_valid", int'(ex_valid), 0);
        chk("d_ar_fwd_a", int'(fwd_sel_a), 0);
        chk("d_ar_count", int'(stall_count), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        model_clear();
        step(1, 5, 1, 3, 1, 6, 1, 0, 0);
        chk("d_ar_first_fwd_a", int'(fwd_sel_a), 0);
        chk("d_ar_first_fwd_b", int'(fwd_sel_b), 0);
        chk("d_ar_first_valid", int'(ex_valid), 1);

        // random traffic over a small register range to provoke hazards
        do_reset();
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            step($urandom_range(0, 9) != 0, $urandom_range(0, 3), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
                 $urandom_range(0, 4) != 0, $urandom_range(0, 1),
                 $urandom_range(0, 15) == 0);
        end
        if (m_cnt >= 15) chk("sat4_pinned", int'(stall_count_s), 15);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/hazard_forward_ctrl.md
HAZARD_FORWARD_CTRL -- requirements
Module: hazard_forward_ctrl

Interface
REQ-001 SHALL have parameter: REG_ADDR_W, default 4, register-address width.
REQ-002 SHALL have parameter: CNT_W, default 16, stall-counter width.
REQ-003 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port: rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port: id_valid  input  1  valid instruction in ID.
REQ-006 SHALL have port: id_src1, id_src2  input  REG_ADDR_W  ID source registers.
REQ-007 SHALL have port: id_use_src1, id_use_src2  input  1  source actually read.
REQ-008 SHALL have port: id_dest  input  REG_ADDR_W  ID destination register.
REQ-009 SHALL have port: id_wb_en  input  1  ID instruction writes the register file.
REQ-010 SHALL have port: id_mem_read  input  1  ID instruction is a load.
REQ-011 SHALL have port: branch_taken  input  1  flush the instruction in ID.
REQ-012 SHALL have port: stall  output  1  hold PC and IF/ID register.
REQ-013 SHALL have port: fwd_sel_a, fwd_sel_b  output  2  operand-mux selects for EX: 0 = register file, 1 = EX/MEM result, 2 = MEM/WB result.
REQ-014 SHALL have port: ex_valid  output  1  EX holds a real instruction.
REQ-015 SHALL have port: stall_count  output  CNT_W  saturating count of stall cycles.

Function
REQ-016 SHALL keep shadow stages EX, MEM and WB, each holding valid, dest, wb_en and mem_read.
REQ-017 SHALL shift every rising edge: MEM <= EX, WB <= MEM; downstream stages never stall.
REQ-018 SHALL compute stall combinationally: id_valid & EX.valid & EX.mem_read & EX.wb_en & EX.dest != 0 & ((id_use_src1 & id_src1 == EX.dest) | (id_use_src2 & id_src2 == EX.dest)).
REQ-019 SHALL force stall to 0 while branch_taken = 1.
REQ-020 SHALL load EX with ID fields when id_valid = 1, stall = 0 and branch_taken = 0; otherwise SHALL load a bubble (valid 0, wb_en 0, mem_read 0, dest 0).
REQ-021 SHALL compute per-operand select at ID time. Select is 1 if the source is used, EX.valid & EX.wb_en, EX.dest == src and src != 0; else 2 if the same conditions hold for MEM; else 0.
REQ-022 SHALL give EX priority over MEM when both match, so the youngest producer wins.
REQ-023 SHALL register fwd_sel_a and fwd_sel_b on the same edge that loads EX, aligned with the instruction they serve; a bubble SHALL register 0 for both.
REQ-024 SHALL never forward from the WB stage; the register file is write-before-read.
REQ-025 SHALL never forward register 0, even when wb_en = 1.
REQ-026 SHALL drive ex_valid from EX.valid.
REQ-027 SHALL increment stall_count on each edge where stall = 1, saturating at all-ones with no wrap.
REQ-028 SHALL NOT stall on a load followed by an instruction that does not use the load destination (use bit 0 or addresses differ).

Reset
REQ-029 SHALL, while rst = 1, clear all shadow stages to bubbles.
REQ-030 SHALL, while rst = 1, clear fwd_sel_a, fwd_sel_b, ex_valid and stall_count to 0.
REQ-031 SHALL hold stall at 0 during reset, since EX.valid = 0.
REQ-032 SHALL discard any in-flight instructions on rst asserted mid-operation; the first post-reset instruction SHALL see fwd_sel = 0.
REQ-033 SHALL take the first edge after rst deasserts as a normal shift.

Verification
REQ-034 SHALL test: add r3 (wb_en, dest 3), then next cycle sub using src1 = 3 -> sub enters EX with fwd_sel_a = 1, fwd_sel_b = 0, stall never 1.
REQ-035 SHALL test: add r3, unrelated instruction, then instruction with src2 = 3 -> fwd_sel_b = 2.
REQ-036 SHALL test: load dest 5 (mem_read), then use src1 = 5 -> stall = 1 for exactly one cycle, one EX bubble, then fwd_sel_a = 2, stall_count = 1.
REQ-037 SHALL test: back-to-back writes to r4 (add, then or), then use r4 -> fwd_sel = 1 (youngest wins); writes to r0 followed by use of r0 -> fwd_sel = 0.
REQ-038 SHALL test: load-use hazard with branch_taken = 1 in the same cycle -> stall = 0, EX bubble, stall_count unchanged.
REQ-039 SHALL test: rst pulsed asynchronously mid-stall -> outputs 0 immediately without a clock edge; stall_count preset near all-ones saturates at 0xFFFF.
